led_frame_buffer: RTL and testbench

Double-buffered 5x7 frame store that sits directly upstream of the column-scanning LED matrix driver. A writer loads columns of pixel data into the back bank through a valid/ready handshake. The driver's one-hot column select indexes the front bank, and the block returns the active-low row pattern for that column. Bank swaps happen only at a scan frame boundary, so a partially written frame is never displayed.

---
 rtl/led_frame_buffer.sv | 117 +++++++++++
 tb/tb_led_frame_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_buffer.sv
// Double-buffered COLS x ROWS frame store for a column-scanning LED matrix driver.
// The writer fills the back bank. Banks swap only at a scan frame boundary, after a frame has been committed.
module led_frame_buffer #(
    parameter int COLS = 5,
    parameter int ROWS = 7
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_col,
    input  logic [ROWS-1:0] wr_data,
    input  logic            wr_last,
    input  logic [COLS-1:0] scan_col,
    output logic [ROWS-1:0] led_row,
    output logic            frame_pending,
    output logic            err_col
);

    typedef enum logic {FILL, WAIT_SWAP} state_t;

    localparam logic [COLS-1:0] FIRST_COL = {1'b1, {(COLS-1){1'b0}}};
    localparam logic [2:0]      COL_LIMIT = 3'(COLS);

    state_t          state_q, state_d;
    logic            front_sel_q, front_sel_d;
    logic [ROWS-1:0] bank0_q [COLS];
    logic [ROWS-1:0] bank0_d [COLS];
    logic [ROWS-1:0] bank1_q [COLS];
    logic [ROWS-1:0] bank1_d [COLS];
    logic [COLS-1:0] scan_prev_q;
    logic [ROWS-1:0] led_row_q, led_row_d;
    logic            wr_ready_q, wr_ready_d;
    logic            frame_pending_q, frame_pending_d;
    logic            err_col_q, err_col_d;

    logic            wr_fire;
    logic            frame_start;
    logic [ROWS-1:0] sel_row;

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        bank0_d     = bank0_q;
        bank1_d     = bank1_q;
        err_col_d   = err_col_q;
        sel_row     = '0;

        wr_fire     = wr_valid && wr_ready_q;
        frame_start = (scan_col == FIRST_COL) && (scan_prev_q != FIRST_COL);

        // Row lookup uses the pre-toggle front bank, so a swap edge still shows the old frame.
        for (int i = 0; i < COLS; i++) begin
            if (scan_col[COLS-1-i])
                sel_row = sel_row | (front_sel_q ? bank1_q[i] : bank0_q[i]);
        end
        led_row_d = $onehot(scan_col) ? ~sel_row : '1;

        for (int i = 0; i < COLS; i++) begin
            if (wr_fire && (wr_col == 3'(i))) begin
                if (front_sel_q) bank0_d[i] = wr_data;
                else             bank1_d[i] = wr_data;
            end
        end
        if (wr_fire && (wr_col >= COL_LIMIT))
            err_col_d = 1'b1;

        case (state_q)
            FILL: begin
                if (wr_fire && wr_last)
                    state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (frame_start) begin
                    state_d     = FILL;
                    front_sel_d = ~front_sel_q;
                end
            end
            default: state_d = FILL;
        endcase

        wr_ready_d      = (state_d == FILL);
        frame_pending_d = (state_d == WAIT_SWAP);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q         <= FILL;
            front_sel_q     <= 1'b0;
            scan_prev_q     <= '0;
            led_row_q       <= '1;
            wr_ready_q      <= 1'b1;
            frame_pending_q <= 1'b0;
            err_col_q       <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            front_sel_q     <= front_sel_d;
            scan_prev_q     <= scan_col;
            led_row_q       <= led_row_d;
            wr_ready_q      <= wr_ready_d;
            frame_pending_q <= frame_pending_d;
            err_col_q       <= err_col_d;
            bank0_q         <= bank0_d;
            bank1_q         <= bank1_d;
        end
    end

    assign wr_ready      = wr_ready_q;
    assign frame_pending = frame_pending_q;
    assign err_col       = err_col_q;
    assign led_row       = led_row_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomised scoreboard bench for led_frame_buffer against a frame-level reference model.
module tb_led_frame_buffer;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_col = '0;
    logic [6:0] wr_data = '0;
    logic       wr_last = 1'b0;
    logic [4:0] scan_col = '0;
    logic [6:0] led_row;
    logic       frame_pending;
    logic       err_col;

    led_frame_buffer #(.COLS(5), .ROWS(7)) dut (
        .clock(clock), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col(wr_col), .wr_data(wr_data), .wr_last(wr_last), .scan_col(scan_col),
        .led_row(led_row), .frame_pending(frame_pending), .err_col(err_col)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] led;
        logic       rdy;
        logic       pend;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Reference: two frames, index of the displayed one, pending/err flags, last scan value.
    logic [6:0] m_frame [2][5];
    int         m_front;
    bit         m_pend;
    bit         m_err;
    logic [4:0] m_prev;

    task automatic model_clear();
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 5; c++) m_frame[f][c] = '0;
        m_front = 0;
        m_pend  = 0;
        m_err   = 0;
        m_prev  = '0;
    endtask

    task automatic do_reset(input logic [4:0] sc);
        exp_t e;
        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; scan_col = sc;
        model_clear();
        e.led = 7'h7F; e.rdy = 1'b1; e.pend = 1'b0; e.err = 1'b0;
        @(posedge clock);
        sb.push_back(e);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input bit v, input logic [2:0] col, input logic [6:0] d,
                        input bit last, input logic [4:0] sc);
        exp_t e;
        bit   pend_before, acc, bnd;
        int   cnt, c;
        wr_valid = v; wr_col = col; wr_data = d; wr_last = last; scan_col = sc;
        cnt = 0; c = 0;
        for (int i = 0; i < 5; i++) if (sc[4-i]) begin cnt++; c = i; end
        e.led = (cnt == 1) ? ~m_frame[m_front][c] : 7'h7F;
        pend_before = m_pend;
        acc = v && !pend_before;
        if (acc) begin
            if (col < 5) m_frame[1-m_front][col] = d;
            else         m_err = 1;
            if (last) m_pend = 1;
        end
        bnd = (sc == 5'b10000) && (m_prev != 5'b10000);
        if (pend_before && bnd) begin
            m_front = 1 - m_front;
            m_pend  = 0;
        end
        m_prev = sc;
        e.rdy  = !m_pend;
        e.pend = m_pend;
        e.err  = m_err;
        @(posedge clock);
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [4:0] sc);
        step(1'b0, 3'd0, 7'h00, 1'b0, sc);
    endtask

    always @(negedge clock) begin
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (led_row !== e.led) begin
                n_bad++;
                $display("FAIL led_row cyc=%0d got=%b exp=%b", cyc, led_row, e.led);
            end
            n_cmp++;
            if (wr_ready !== e.rdy) begin
                n_bad++;
                $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, e.rdy);
            end
            n_cmp++;
            if (frame_pending !== e.pend) begin
                n_bad++;
                $display("FAIL frame_pending cyc=%0d got=%b exp=%b", cyc, frame_pending, e.pend);
            end
            n_cmp++;
            if (err_col !== e.err) begin
                n_bad++;
                $display("FAIL err_col cyc=%0d got=%b exp=%b", cyc, err_col, e.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] sc;
        #1;
        do_reset(5'b10000);
        idle(5'b10000);
        idle(5'b01000);

        for (int c = 0; c < 5; c++)
            step(1'b1, 3'(c), 7'(1 << c), c == 4, 5'b01000);
        idle(5'b01000);
        idle(5'b01000);
        idle(5'b00001);
        idle(5'b10000);
        idle(5'b10000);
        idle(5'b01000);
        idle(5'b00001);

        step(1'b1, 3'd6, 7'h7F, 1'b0, 5'b00100);
        step(1'b1, 3'd1, 7'h55, 1'b0, 5'b00010);
        idle(5'b10000);
        step(1'b1, 3'd3, 7'h2A, 1'b1, 5'b10000);
        for (int k = 0; k < 6; k++) idle(5'b10000);
        idle(5'b01000);
        idle(5'b10000);
        idle(5'b10000);
        idle(5'b01000);
        idle(5'b00100);
        idle(5'b00010);
        idle(5'b00001);
        idle(5'b00000);
        idle(5'b11000);
        idle(5'b00000);

        step(1'b1, 3'd2, 7'h3C, 1'b0, 5'b00100);
        step(1'b1, 3'd0, 7'h11, 1'b1, 5'b00010);
        idle(5'b00001);
        do_reset(5'b00001);
        idle(5'b10000);
        idle(5'b01000);
        idle(5'b00100);
        idle(5'b00010);
        idle(5'b00001);
        idle(5'b00001);

        sc = 5'b10000;
        for (int k = 0; k < 3000; k++) begin
            bit         v, last;
            logic [2:0] col;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(sc);
            end else begin
                if ($urandom_range(0, 9) < 8) sc = {sc[0], sc[4:1]};
                else                          sc = 5'($urandom);
                if (sc == 5'b00000 && $urandom_range(0, 1) == 1) sc = 5'b10000;
                v    = ($urandom_range(0, 1) == 1);
                col  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                  : 3'($urandom_range(5, 7));
                last = ($urandom_range(0, 9) == 0);
                step(v, col, 7'($urandom), last, sc);
            end
        end

        for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0 entries left", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
